// File: rtl/mfp_ahb_keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one active-low column at a time, samples
// the synchronized rows at the end of each column window, builds a full-scan
// key map, rejects ghosting (more than one key) and debounces the result over
// DEBOUNCE_SCANS identical scans before reporting press/release events.
module mfp_ahb_keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       resetn,
  output logic [3:0] COL_OUT,
  input  logic [3:0] ROW_IN,
  output logic [3:0] KEY_CODE,
  output logic       KEY_VALID,
  output logic       KEY_PRESS,
  output logic       KEY_RELEASE
);

  localparam logic [15:0] DIV_LAST   = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DEB_TARGET = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // stable result is "no key"
    ST_HELD = 2'd1,  // stable result is a key
    ST_PEND = 2'd2   // candidate differs from the stable result
  } state_t;

  // Candidate / stable values are {valid, code}; 5'b0 means "no key".
  localparam logic [4:0] KEY_NONE = 5'b0_0000;

  logic [3:0]  r_row_meta;
  logic [3:0]  r_row_sync;
  logic [15:0] r_div;
  logic [1:0]  r_col;
  logic [3:0]  r_col_out;
  logic [15:0] r_map;
  state_t      r_state;
  logic [4:0]  r_stable;
  logic [4:0]  r_pending;
  logic [3:0]  r_count;
  logic [3:0]  r_key_code;
  logic        r_key_valid;
  logic        r_key_press;
  logic        r_key_release;

  logic        w_div_last;
  logic        w_scan_end;
  logic [1:0]  w_next_col;
  logic [15:0] w_map_full;
  logic [4:0]  w_ones;
  logic [3:0]  w_idx;
  logic [4:0]  w_cand;
  state_t      w_state_nxt;
  logic [4:0]  w_stable_nxt;
  logic [4:0]  w_pending_nxt;
  logic [3:0]  w_count_nxt;
  logic [3:0]  w_count_inc;
  logic        w_accept;
  logic        w_press;
  logic        w_release;
  logic [3:0]  w_code_nxt;
  logic        w_valid_nxt;

  // Map index col*4+row to the hex legend printed on the keypad.
  function automatic logic [3:0] key_map(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:  code = 4'h1;  4'd1:  code = 4'h4;  4'd2:  code = 4'h7;  4'd3:  code = 4'h0;
      4'd4:  code = 4'h2;  4'd5:  code = 4'h5;  4'd6:  code = 4'h8;  4'd7:  code = 4'hF;
      4'd8:  code = 4'h3;  4'd9:  code = 4'h6;  4'd10: code = 4'h9;  4'd11: code = 4'hE;
      4'd12: code = 4'hA;  4'd13: code = 4'hB;  4'd14: code = 4'hC;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  assign w_div_last = (r_div == DIV_LAST);
  assign w_scan_end = w_div_last && (r_col == 2'd3);
  assign w_next_col = r_col + 2'd1;
  assign w_map_full = r_map | ({12'd0, ~r_row_sync} << {r_col, 2'b00});

  // Two-flop synchronizer for the asynchronous row inputs (idle = pulled up).
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!resetn) begin
      r_row_meta <= 4'hF;
      r_row_sync <= 4'hF;
    end else begin
      r_row_meta <= ROW_IN;
      r_row_sync <= r_row_meta;
    end
  end

  // Column divider, column drive and per-scan key map accumulation.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_div     <= 16'd0;
      r_col     <= 2'd0;
      r_col_out <= 4'b1110;
      // NOTE: the scan map is reset too, so a reset mid-scan cannot leak
      // stale key bits into the first scan after reset.
      r_map     <= 16'd0;
    end else if (w_div_last) begin
      r_div     <= 16'd0;
      r_col     <= w_next_col;
      r_col_out <= ~(4'b0001 << w_next_col);
      r_map     <= w_scan_end ? 16'd0 : w_map_full;
    end else begin
      r_div     <= r_div + 16'd1;
    end
  end

  // Candidate key: exactly one bit set in the complete map, otherwise none.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves a variable unassigned (which would infer a latch).
    w_ones = 5'd0;
    w_idx  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (w_map_full[i]) begin
        w_ones = 5'(w_ones + 5'd1);
        w_idx  = 4'(i);
      end
    end
    w_cand = (w_ones == 5'd1) ? {1'b1, key_map(w_idx)} : KEY_NONE;
  end

  // Debounce next-state logic, evaluated only on the scan-end cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_stable_nxt  = r_stable;
    w_pending_nxt = r_pending;
    w_count_nxt   = r_count;
    w_accept      = 1'b0;
    w_count_inc   = (r_count == 4'hF) ? r_count : 4'(r_count + 4'd1);
    if (w_scan_end) begin
      case (r_state)
        ST_IDLE, ST_HELD: begin
          if (w_cand == r_stable) begin
            w_count_nxt = 4'd0;
          end else begin
            w_state_nxt   = ST_PEND;
            w_pending_nxt = w_cand;
            w_count_nxt   = 4'd1;
          end
        end
        ST_PEND: begin
          if (w_cand == r_pending) begin
            w_count_nxt = w_count_inc;
          end else if (w_cand == r_stable) begin
            w_state_nxt = r_stable[4] ? ST_HELD : ST_IDLE;
            w_count_nxt = 4'd0;
          end else begin
            w_pending_nxt = w_cand;
            w_count_nxt   = 4'd1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_count_nxt = 4'd0;
        end
      endcase
      if ((w_state_nxt == ST_PEND) && (w_count_nxt >= DEB_TARGET)) begin
        w_accept     = 1'b1;
        w_stable_nxt = w_pending_nxt;
        w_state_nxt  = w_pending_nxt[4] ? ST_HELD : ST_IDLE;
        w_count_nxt  = 4'd0;
      end
    end
    w_press     = w_accept &  w_pending_nxt[4];
    w_release   = w_accept & ~w_pending_nxt[4];
    w_code_nxt  = w_press  ? w_pending_nxt[3:0] : r_key_code;
    w_valid_nxt = w_accept ? w_pending_nxt[4]   : r_key_valid;
  end

  // Debounce state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_stable  <= KEY_NONE;
      r_pending <= KEY_NONE;
      r_count   <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_stable  <= w_stable_nxt;
      r_pending <= w_pending_nxt;
      r_count   <= w_count_nxt;
    end
  end

  // Registered key outputs; pulses land the cycle after scan end.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_key_code    <= 4'd0;
      r_key_valid   <= 1'b0;
      r_key_press   <= 1'b0;
      r_key_release <= 1'b0;
    end else begin
      r_key_code    <= w_code_nxt;
      r_key_valid   <= w_valid_nxt;
      r_key_press   <= w_press;
      r_key_release <= w_release;
    end
  end

  assign COL_OUT     = r_col_out;
  assign KEY_CODE    = r_key_code;
  assign KEY_VALID   = r_key_valid;
  assign KEY_PRESS   = r_key_press;
  assign KEY_RELEASE = r_key_release;

endmodule

// File: tb/tb_mfp_ahb_keypad_scanner.sv
// Directed bench for the keypad scanner with SCAN_DIV=8, DEBOUNCE_SCANS=3
// (one scan = 32 cycles). A behavioural 4x4 key matrix drives ROW_IN from
// COL_OUT and the set of keys held by the bench.
module tb_mfp_ahb_keypad_scanner;

  localparam int SCAN_DIV = 8;
  localparam int DEB      = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  col_out;
  logic [3:0]  row_in;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_press;
  logic        key_release;

  // Held keys, bit index = col*4 + row.
  logic [15:0] pressed = 16'h0000;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int press_total = 0;
  int release_total = 0;
  int both_total = 0;
  int last_press_cyc = -1;
  int last_release_cyc = -1;
  int p0;
  int r0;

  mfp_ahb_keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .COL_OUT    (col_out),
    .ROW_IN     (row_in),
    .KEY_CODE   (key_code),
    .KEY_VALID  (key_valid),
    .KEY_PRESS  (key_press),
    .KEY_RELEASE(key_release)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a held key pulls its row low while its column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col_out[c] && pressed[c*4 + r]) row_in[r] = 1'b0;
  end

  // Cycles since reset release: after posedge n (counted from 0) cyc = n+1.
  always @(posedge clk) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // Pulse monitor.
  always @(negedge clk) begin
    if (key_press === 1'b1) begin
      press_total++;
      last_press_cyc = cyc;
    end
    if (key_release === 1'b1) begin
      release_total++;
      last_release_cyc = cyc;
    end
    if (key_press === 1'b1 && key_release === 1'b1) both_total++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [15:0] keys);
    resetn = 1'b0;
    tick(2);
    pressed = keys;
    resetn  = 1'b1;
  endtask

  initial begin
    int col_err;
    int valid_err;
    logic [3:0] exp_col;

    // Reset values
    resetn = 1'b0;
    tick(3);
    check("rst_col_out", 32'(col_out), 32'h0000_000E);
    check("rst_key_code", 32'(key_code), 32'h0);
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_key_press", 32'(key_press), 32'h0);
    check("rst_key_release", 32'(key_release), 32'h0);

    // Idle for 20 scans: column rotation, nothing reported
    pressed = 16'h0000;
    resetn  = 1'b1;
    p0 = press_total;
    r0 = release_total;
    col_err   = 0;
    valid_err = 0;
    for (int i = 0; i < 20 * 32; i++) begin
      tick(1);
      exp_col = ~(4'b0001 << ((cyc / SCAN_DIV) % 4));
      if (col_out !== exp_col) col_err++;
      if (key_valid !== 1'b0) valid_err++;
    end
    check("idle_col_pattern_errs", 32'(col_err), 32'd0);
    check("idle_valid_errs", 32'(valid_err), 32'd0);
    check("idle_press_cnt", 32'(press_total - p0), 32'd0);
    check("idle_release_cnt", 32'(release_total - r0), 32'd0);

    // Key '5' held 6 scans, then released
    start(16'h0020);
    p0 = press_total;
    r0 = release_total;
    tick(95);
    check("k5_valid_before", 32'(key_valid), 32'd0);
    check("k5_press_before", 32'(key_press), 32'd0);
    tick(1);
    check("k5_press_pulse", 32'(key_press), 32'd1);
    check("k5_valid", 32'(key_valid), 32'd1);
    check("k5_code", 32'(key_code), 32'h5);
    tick(1);
    check("k5_press_one_cycle", 32'(key_press), 32'd0);
    tick(95);
    check("k5_press_cnt", 32'(press_total - p0), 32'd1);
    check("k5_press_cyc", 32'(last_press_cyc), 32'd96);
    check("k5_still_valid", 32'(key_valid), 32'd1);
    pressed = 16'h0000;
    tick(95);
    check("k5_release_before", 32'(key_release), 32'd0);
    check("k5_valid_before_rel", 32'(key_valid), 32'd1);
    tick(1);
    check("k5_release_pulse", 32'(key_release), 32'd1);
    check("k5_valid_dropped", 32'(key_valid), 32'd0);
    check("k5_code_held", 32'(key_code), 32'h5);
    tick(32);
    check("k5_release_cnt", 32'(release_total - r0), 32'd1);
    check("k5_release_cyc", 32'(last_release_cyc), 32'd288);
    check("k5_press_cnt_final", 32'(press_total - p0), 32'd1);

    // Bouncing 'D': present on alternate scans only
    start(16'h8000);
    p0 = press_total;
    for (int s = 0; s < 8; s++) begin
      pressed = (s % 2 == 0) ? 16'h8000 : 16'h0000;
      tick(32);
    end
    check("bounce_press_cnt", 32'(press_total - p0), 32'd0);
    check("bounce_valid", 32'(key_valid), 32'd0);

    // Ghosting: '1' and '9' together, then '9' released
    start(16'h0401);
    p0 = press_total;
    r0 = release_total;
    tick(128);
    check("ghost_press_cnt", 32'(press_total - p0), 32'd0);
    check("ghost_valid", 32'(key_valid), 32'd0);
    pressed = 16'h0001;
    tick(95);
    check("ghost_no_early_press", 32'(press_total - p0), 32'd0);
    tick(1);
    check("k1_press_pulse", 32'(key_press), 32'd1);
    check("k1_code", 32'(key_code), 32'h1);
    check("k1_valid", 32'(key_valid), 32'd1);
    tick(32);
    check("k1_press_cnt", 32'(press_total - p0), 32'd1);
    check("k1_release_cnt", 32'(release_total - r0), 32'd0);

    // 'A' then directly 'E'
    start(16'h1000);
    p0 = press_total;
    r0 = release_total;
    tick(128);
    check("kA_press_cnt", 32'(press_total - p0), 32'd1);
    check("kA_code", 32'(key_code), 32'hA);
    check("kA_press_cyc", 32'(last_press_cyc), 32'd96);
    pressed = 16'h0800;
    tick(95);
    check("kAE_code_before", 32'(key_code), 32'hA);
    tick(1);
    check("kE_press_pulse", 32'(key_press), 32'd1);
    check("kE_release_low", 32'(key_release), 32'd0);
    check("kE_code", 32'(key_code), 32'hE);
    tick(32);
    check("kE_press_cnt", 32'(press_total - p0), 32'd2);
    check("kE_release_cnt", 32'(release_total - r0), 32'd0);
    check("kE_valid", 32'(key_valid), 32'd1);
    // Reset while a key is held clears the reported key
    resetn = 1'b0;
    tick(1);
    check("held_rst_code", 32'(key_code), 32'h0);
    check("held_rst_valid", 32'(key_valid), 32'd0);

    // Reset pulse during the 2nd debounce scan of 'C'
    start(16'h4000);
    tick(45);
    resetn = 1'b0;
    tick(1);
    check("midrst_col_out", 32'(col_out), 32'h0000_000E);
    check("midrst_code", 32'(key_code), 32'h0);
    check("midrst_valid", 32'(key_valid), 32'd0);
    check("midrst_press", 32'(key_press), 32'd0);
    check("midrst_release", 32'(key_release), 32'd0);
    resetn = 1'b1;
    p0 = press_total;
    tick(95);
    check("kC_no_early_press", 32'(press_total - p0), 32'd0);
    check("kC_valid_before", 32'(key_valid), 32'd0);
    tick(1);
    check("kC_press_pulse", 32'(key_press), 32'd1);
    check("kC_code", 32'(key_code), 32'hC);
    tick(1);
    check("kC_press_cnt", 32'(press_total - p0), 32'd1);

    check("press_release_overlap", 32'(both_total), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
